// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_unit
//  Description : Iterative HI/LO multiply/divide unit for the MIPS datapath.
//                Shift-add multiply and restoring divide, one iteration per
//                enabled clock, with sign correction applied at the end.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [CW-1:0]    count;
  logic             is_div;
  logic             neg_q;      // sign of product / quotient
  logic             neg_r;      // sign of remainder (follows dividend)
  logic             div_zero;
  logic [WIDTH-1:0] b_mag;      // multiplicand or divisor magnitude
  logic [WIDTH-1:0] p_hi;       // product high half / partial remainder
  logic [WIDTH-1:0] p_lo;       // multiplier shifting out / quotient shifting in
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;

  logic             is_start_md;
  logic             a_sgn;
  logic             b_sgn;
  logic [WIDTH-1:0] a_mag_in;
  logic [WIDTH-1:0] b_mag_in;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_trial;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  assign busy = (state != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  // Operand conditioning and per-iteration arithmetic
  always_comb begin
    is_start_md = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    a_sgn       = ((op == OP_MULT) || (op == OP_DIV)) && op_a[WIDTH-1];
    b_sgn       = ((op == OP_MULT) || (op == OP_DIV)) && op_b[WIDTH-1];
    a_mag_in    = a_sgn ? (-op_a) : op_a;
    b_mag_in    = b_sgn ? (-op_b) : op_b;
    mul_sum     = {1'b0, p_hi} + {1'b0, (p_lo[0] ? b_mag : {WIDTH{1'b0}})};
    div_trial   = {p_hi, p_lo[WIDTH-1]} - {1'b0, b_mag};
    prod_fix    = neg_q ? (-{p_hi, p_lo}) : {p_hi, p_lo};
    quo_fix     = neg_q ? (-p_lo) : p_lo;
    rem_fix     = neg_r ? (-p_hi) : p_hi;
  end

  // State register, advances only on enabled edges
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else if (clk_enable) begin
      state <= state_next;
    end
  end

  // Next-state logic; FINISH never accepts a new start
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start && is_start_md) state_next = S_RUN;
      S_RUN:    if (count == CW'(WIDTH - 1)) state_next = S_FINISH;
      S_FINISH: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Working registers, iteration datapath and architectural HI/LO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      b_mag    <= '0;
      p_hi     <= '0;
      p_lo     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else if (clk_enable) begin
      done_q <= (state == S_FINISH);
      case (state)
        S_IDLE: begin
          if (start) begin
            if (is_start_md) begin
              b_mag    <= b_mag_in;
              p_hi     <= '0;
              p_lo     <= a_mag_in;
              is_div   <= op[1];
              neg_q    <= a_sgn ^ b_sgn;
              neg_r    <= a_sgn;
              div_zero <= (op_b == '0);
              count    <= '0;
            end else if (op == OP_MTHI) begin
              hi_q <= op_a;
            end else if (op == OP_MTLO) begin
              lo_q <= op_a;
            end
          end
        end
        S_RUN: begin
          count <= count + CW'(1);
          if (is_div) begin
            // Restoring step: keep the subtraction only if it did not go negative
            if (!div_trial[WIDTH]) begin
              p_hi <= div_trial[WIDTH-1:0];
              p_lo <= {p_lo[WIDTH-2:0], 1'b1};
            end else begin
              p_hi <= {p_hi[WIDTH-2:0], p_lo[WIDTH-1]};
              p_lo <= {p_lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            p_hi <= mul_sum[WIDTH:1];
            p_lo <= {mul_sum[0], p_lo[WIDTH-1:1]};
          end
        end
        S_FINISH: begin
          if (is_div) begin
            if (!div_zero) begin
              lo_q <= quo_fix;
              hi_q <= rem_fix;
            end
          end else begin
            {hi_q, lo_q} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_div_unit
//  Description : Self-checking bench for mult_div_unit: directed cases plus
//                randomized operations against a 64-bit arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        clk_enable;
  logic        start;
  logic [2:0]  op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          checks;
  int          errors;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .start      (start),
    .op         (op),
    .op_a       (op_a),
    .op_b       (op_b),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural reference: plain 64-bit arithmetic on the operands
  task automatic model_apply(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint      sa, sb, q, r;
    case (o)
      3'd0: begin
        p = longint'($signed(a)) * longint'($signed(b));
        m_hi = p[63:32]; m_lo = p[31:0];
      end
      3'd1: begin
        p = {32'b0, a} * {32'b0, b};
        m_hi = p[63:32]; m_lo = p[31:0];
      end
      3'd2: if (b != 0) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q = sa / sb;
        r = sa % sb;
        m_lo = q[31:0]; m_hi = r[31:0];
      end
      3'd3: if (b != 0) begin
        m_lo = a / b; m_hi = a % b;
      end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: ;
    endcase
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
    int n;
    int bc;
    bit got;
    @(negedge clk);
    op = o; op_a = a; op_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op_a = $urandom; op_b = $urandom;
    model_apply(o, a, b);
    if (o <= 3'd3) begin
      check({tag, " busy_after_start"}, {31'b0, busy}, 32'd1);
      n = 0; bc = busy ? 1 : 0; got = 1'b0;
      while (!got && n < 60) begin
        @(negedge clk);
        n++;
        if (done) got = 1'b1;
        else if (busy) bc++;
      end
      check({tag, " latency"}, n, 32'd33);
      check({tag, " busy_cycles"}, bc, 32'd33);
      check({tag, " busy_at_done"}, {31'b0, busy}, 32'd0);
      check({tag, " hi"}, hi, m_hi);
      check({tag, " lo"}, lo, m_lo);
      @(negedge clk);
      check({tag, " done_clears"}, {31'b0, done}, 32'd0);
    end else begin
      check({tag, " busy"}, {31'b0, busy}, 32'd0);
      check({tag, " done"}, {31'b0, done}, 32'd0);
      check({tag, " hi"}, hi, m_hi);
      check({tag, " lo"}, lo, m_lo);
    end
  endtask

  initial begin
    int n;
    bit got;
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    checks = 0; errors = 0;
    m_hi = '0; m_lo = '0;
    reset = 1'b1; clk_enable = 1'b1; start = 1'b0; op = 3'd7; op_a = '0; op_b = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset done", {31'b0, done}, 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    reset = 1'b0;

    // Directed arithmetic cases
    run_op(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, "multu_max_x2");
    check("multu_max_x2 hi_const", hi, 32'h0000_0001);
    check("multu_max_x2 lo_const", lo, 32'hFFFF_FFFE);
    run_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0002, "mult_m1_x2");
    check("mult_m1_x2 hi_const", hi, 32'hFFFF_FFFF);
    run_op(3'd0, 32'h8000_0000, 32'h8000_0000, "mult_min_sq");
    check("mult_min_sq hi_const", hi, 32'h4000_0000);
    run_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, "div_m7_2");
    check("div_m7_2 lo_const", lo, 32'hFFFF_FFFD);
    check("div_m7_2 hi_const", hi, 32'hFFFF_FFFF);
    run_op(3'd3, 32'd100, 32'd7, "divu_100_7");
    check("divu_100_7 lo_const", lo, 32'd14);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
    check("div_overflow lo_const", lo, 32'h8000_0000);
    check("div_overflow hi_const", hi, 32'd0);

    // Divide by zero keeps preset HI/LO
    run_op(3'd4, 32'h0000_1111, 32'h0, "mthi_preset");
    run_op(3'd5, 32'h0000_2222, 32'h0, "mtlo_preset");
    run_op(3'd3, 32'h1234_5678, 32'h0, "divu_by_zero");
    check("divu_by_zero hi_const", hi, 32'h0000_1111);
    check("divu_by_zero lo_const", lo, 32'h0000_2222);
    run_op(3'd4, 32'h0000_ABCD, 32'h0, "mthi_abcd");
    run_op(3'd6, 32'hDEAD_BEEF, 32'h1, "noop6");

    // Stalls, operand changes and ignored start during a run
    @(negedge clk);
    op = 3'd1; op_a = 32'd3; op_b = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model_apply(3'd1, 32'd3, 32'd5);
    n = 0; got = 1'b0;
    while (!got && n < 80) begin
      case (n)
        3:  begin op_a = 32'hDEAD_BEEF; op_b = 32'h0000_0003; end
        5:  begin op = 3'd3; start = 1'b1; end
        6:  start = 1'b0;
        7:  begin op = 3'd4; start = 1'b1; end
        8:  start = 1'b0;
        10: clk_enable = 1'b0;
        20: clk_enable = 1'b1;
        default: ;
      endcase
      @(negedge clk);
      n++;
      if (done) got = 1'b1;
    end
    check("stall latency", n, 32'd43);
    check("stall hi", hi, 32'd0);
    check("stall lo", lo, 32'd15);
    clk_enable = 1'b0;
    repeat (3) @(negedge clk);
    check("stall done_stretched", {31'b0, done}, 32'd1);
    clk_enable = 1'b1;
    @(negedge clk);
    check("stall done_clears", {31'b0, done}, 32'd0);

    // Asynchronous reset in the middle of a run
    run_op(3'd4, 32'h0000_5555, 32'h0, "mthi_before_reset");
    @(negedge clk);
    op = 3'd1; op_a = 32'h0001_2345; op_b = 32'h0000_0777; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (17) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_reset busy", {31'b0, busy}, 32'd0);
    check("async_reset done", {31'b0, done}, 32'd0);
    check("async_reset hi", hi, 32'd0);
    check("async_reset lo", lo, 32'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    run_op(3'd1, 32'd2, 32'd3, "multu_after_reset");
    check("multu_after_reset lo_const", lo, 32'd6);

    // Randomized operations
    for (int i = 0; i < 24; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 20));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      run_op(ro, ra, rb, $sformatf("rand%0d_op%0d", i, ro));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
